// File: rtl/wb_pkg.sv
// Shared widths and the queued write record used by the writeback arbiter.
package wb_pkg;

    localparam int WB_DATA_W = 16;
    localparam int WB_ADDR_W = 3;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer for ALU writes waiting on the register-file port.
// Entries are presented oldest-first (index 0 = head) with a matching valid mask.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  wb_entry_t        push_entry,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output wb_entry_t        entries [DEPTH],
    output logic [DEPTH-1:0] valid
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    logic [IDX_W-1:0] head_idx, tail_idx;
    logic             head_wrap, tail_wrap;
    wb_entry_t        mem [DEPTH];

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == LAST) ? '0 : idx + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_idx  <= '0;
            tail_idx  <= '0;
            head_wrap <= 1'b0;
            tail_wrap <= 1'b0;
        end else begin
            if (push) begin
                tail_idx <= next_idx(tail_idx);
                if (tail_idx == LAST) tail_wrap <= ~tail_wrap;
            end
            if (pop) begin
                head_idx <= next_idx(head_idx);
                if (head_idx == LAST) head_wrap <= ~head_wrap;
            end
        end
    end

    // Storage carries no reset; the valid mask hides stale contents.
    always_ff @(posedge clk) begin
        if (push) mem[tail_idx] <= push_entry;
    end

    assign empty = (head_idx == tail_idx) && (head_wrap == tail_wrap);
    assign full  = (head_idx == tail_idx) && (head_wrap != tail_wrap);

    always_comb begin
        if (head_wrap == tail_wrap)
            count = CNT_W'(int'(tail_idx) - int'(head_idx));
        else
            count = CNT_W'(DEPTH - int'(head_idx) + int'(tail_idx));
    end

    always_comb begin
        int p;
        p = 0;
        for (int i = 0; i < DEPTH; i++) begin
            p = int'(head_idx) + i;
            if (p >= DEPTH) p = p - DEPTH;
            entries[i] = mem[p[IDX_W-1:0]];
            valid[i]   = (i < int'(count));
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Single register-file write port shared by load data (highest priority) and
// queued/bypassed ALU results, with youngest-first forwarding of pending writes.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = 2,
    localparam int PEND_W = $clog2(DEPTH + 2)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_rd,
    input  logic [DATA_W-1:0] ld_data,
    output logic              we,
    output logic [ADDR_W-1:0] wa,
    output logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] rd_a1,
    input  logic [ADDR_W-1:0] rd_a2,
    output logic              fwd_hit1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2,
    output logic [PEND_W-1:0] pending
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    wb_entry_t        q_entries [DEPTH];
    logic [DEPTH-1:0] q_valid;
    wb_entry_t        alu_entry, slot;
    logic             alu_xfer, slot_we;

    assign alu_entry = '{rd: alu_rd, data: alu_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fifo_push),
        .push_entry (alu_entry),
        .pop        (fifo_pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .entries    (q_entries),
        .valid      (q_valid)
    );

    // Ready depends only on stored state, so a same-cycle pop never frees a full queue.
    assign alu_ready = rst_n && !fifo_full;

    always_comb begin
        alu_xfer  = alu_valid && alu_ready;
        fifo_pop  = !ld_valid && !fifo_empty;
        fifo_push = alu_xfer && (ld_valid || !fifo_empty);
        slot_we   = ld_valid || !fifo_empty || alu_xfer;
        if (ld_valid)         slot = '{rd: ld_rd, data: ld_data};
        else if (!fifo_empty) slot = q_entries[0];
        else                  slot = alu_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we <= 1'b0;
            wa <= '0;
            wd <= '0;
        end else begin
            we <= slot_we;
            if (slot_we) begin
                wa <= slot.rd;
                wd <= slot.data;
            end
        end
    end

    assign pending = PEND_W'(fifo_count) + PEND_W'(we);

    // Oldest candidate first, so later (younger) matches overwrite earlier ones.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_data1 = '0;
        fwd_hit2  = 1'b0;
        fwd_data2 = '0;
        if (we && wa == rd_a1) begin
            fwd_hit1  = 1'b1;
            fwd_data1 = wd;
        end
        if (we && wa == rd_a2) begin
            fwd_hit2  = 1'b1;
            fwd_data2 = wd;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (q_valid[i] && q_entries[i].rd == rd_a1) begin
                fwd_hit1  = 1'b1;
                fwd_data1 = q_entries[i].data;
            end
            if (q_valid[i] && q_entries[i].rd == rd_a2) begin
                fwd_hit2  = 1'b1;
                fwd_data2 = q_entries[i].data;
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed vector table plus randomized run against a queue-based reference model.
module tb_writeback_arbiter;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        alu_valid, alu_ready;
    logic [2:0]  alu_rd;
    logic [15:0] alu_data;
    logic        ld_valid;
    logic [2:0]  ld_rd;
    logic [15:0] ld_data;
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [2:0]  rd_a1, rd_a2;
    logic        fwd_hit1, fwd_hit2;
    logic [15:0] fwd_data1, fwd_data2;
    logic [1:0]  pending;

    int checks   = 0;
    int failures = 0;

    writeback_arbiter #(.DATA_W(16), .ADDR_W(3), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .rd_a1     (rd_a1),
        .rd_a2     (rd_a2),
        .fwd_hit1  (fwd_hit1),
        .fwd_hit2  (fwd_hit2),
        .fwd_data1 (fwd_data1),
        .fwd_data2 (fwd_data2),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of waiting writes plus the visible write register.
    typedef struct {
        logic [2:0]  rd;
        logic [15:0] data;
    } ment_t;

    ment_t       mq[$];
    logic        m_we;
    logic [2:0]  m_wa;
    logic [15:0] m_wd;

    task automatic model_reset();
        mq.delete();
        m_we = 1'b0;
        m_wa = '0;
        m_wd = '0;
    endtask

    function automatic void model_lookup(input logic [2:0] addr, output logic hit, output logic [15:0] data);
        hit  = 1'b0;
        data = '0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].rd == addr) begin
                hit  = 1'b1;
                data = mq[i].data;
                return;
            end
        end
        if (m_we && m_wa == addr) begin
            hit  = 1'b1;
            data = m_wd;
        end
    endfunction

    task automatic model_step();
        bit    xfer;
        ment_t e;
        xfer = alu_valid && (mq.size() < DEPTH);
        if (ld_valid) begin
            m_we = 1'b1; m_wa = ld_rd; m_wd = ld_data;
            if (xfer) mq.push_back('{alu_rd, alu_data});
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m_we = 1'b1; m_wa = e.rd; m_wd = e.data;
            if (xfer) mq.push_back('{alu_rd, alu_data});
        end else if (xfer) begin
            m_we = 1'b1; m_wa = alu_rd; m_wd = alu_data;
        end else begin
            m_we = 1'b0;
        end
    endtask

    task automatic model_compare(input string tag);
        logic        h1, h2;
        logic [15:0] d1, d2;
        model_lookup(rd_a1, h1, d1);
        model_lookup(rd_a2, h2, d2);
        chk({tag, ".alu_ready"}, 32'(alu_ready), 32'(mq.size() < DEPTH));
        chk({tag, ".we"},        32'(we),        32'(m_we));
        chk({tag, ".wa"},        32'(wa),        32'(m_wa));
        chk({tag, ".wd"},        32'(wd),        32'(m_wd));
        chk({tag, ".pending"},   32'(pending),   32'(mq.size() + int'(m_we)));
        chk({tag, ".fwd_hit1"},  32'(fwd_hit1),  32'(h1));
        chk({tag, ".fwd_data1"}, 32'(fwd_data1), 32'(d1));
        chk({tag, ".fwd_hit2"},  32'(fwd_hit2),  32'(h2));
        chk({tag, ".fwd_data2"}, 32'(fwd_data2), 32'(d2));
    endtask

    task automatic drive(input logic av, input logic [2:0] ard, input logic [15:0] ad,
                         input logic lv, input logic [2:0] lrd, input logic [15:0] ldd,
                         input logic [2:0] a1, input logic [2:0] a2);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        ld_valid  = lv; ld_rd  = lrd; ld_data  = ldd;
        rd_a1     = a1; rd_a2  = a2;
    endtask

    typedef struct {
        logic        av;
        logic [2:0]  ard;
        logic [15:0] ad;
        logic        lv;
        logic [2:0]  lrd;
        logic [15:0] ldd;
        logic [2:0]  a1, a2;
        logic        e_rdy, e_we;
        logic [2:0]  e_wa;
        logic [15:0] e_wd;
        logic [1:0]  e_pend;
        logic        e_h1;
        logic [15:0] e_d1;
        logic        e_h2;
        logic [15:0] e_d2;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    initial begin
        // Expected outputs describe state before the edge at which the row's inputs are taken.
        //            av ard ad        lv lrd ld        a1 a2   rdy we wa wd        pnd h1 d1        h2 d2
        vecs[0]  = '{1, 3, 16'h1234, 0, 0, 16'h0000, 3, 0,  1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000};
        vecs[1]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 3, 0,  1, 1, 3, 16'h1234, 1, 1, 16'h1234, 0, 16'h0000};
        vecs[2]  = '{1, 2, 16'h0007, 1, 5, 16'hBEEF, 3, 5,  1, 0, 3, 16'h1234, 0, 0, 16'h0000, 0, 16'h0000};
        vecs[3]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 2, 5,  1, 1, 5, 16'hBEEF, 2, 1, 16'h0007, 1, 16'hBEEF};
        vecs[4]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 2, 5,  1, 1, 2, 16'h0007, 1, 1, 16'h0007, 0, 16'h0000};
        vecs[5]  = '{1, 1, 16'h0011, 1, 6, 16'hAAAA, 1, 2,  1, 0, 2, 16'h0007, 0, 0, 16'h0000, 0, 16'h0000};
        vecs[6]  = '{1, 2, 16'h0022, 1, 6, 16'hBBBB, 1, 2,  1, 1, 6, 16'hAAAA, 2, 1, 16'h0011, 0, 16'h0000};
        vecs[7]  = '{1, 7, 16'h0077, 1, 6, 16'hCCCC, 1, 2,  0, 1, 6, 16'hBBBB, 3, 1, 16'h0011, 1, 16'h0022};
        vecs[8]  = '{1, 7, 16'h0077, 0, 0, 16'h0000, 7, 6,  0, 1, 6, 16'hCCCC, 3, 0, 16'h0000, 1, 16'hCCCC};
        vecs[9]  = '{1, 7, 16'h0077, 0, 0, 16'h0000, 7, 1,  1, 1, 1, 16'h0011, 2, 0, 16'h0000, 1, 16'h0011};
        vecs[10] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 7, 2,  1, 1, 2, 16'h0022, 2, 1, 16'h0077, 1, 16'h0022};
        vecs[11] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 7, 0,  1, 1, 7, 16'h0077, 1, 1, 16'h0077, 0, 16'h0000};
        vecs[12] = '{1, 4, 16'h0001, 1, 4, 16'h0000, 4, 6,  1, 0, 7, 16'h0077, 0, 0, 16'h0000, 0, 16'h0000};
        vecs[13] = '{1, 4, 16'h0002, 1, 4, 16'h0000, 4, 6,  1, 1, 4, 16'h0000, 2, 1, 16'h0001, 0, 16'h0000};
        vecs[14] = '{0, 0, 16'h0000, 1, 3, 16'h3333, 4, 6,  0, 1, 4, 16'h0000, 3, 1, 16'h0002, 0, 16'h0000};
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset.we",        32'(we),        0);
        chk("reset.wa",        32'(wa),        0);
        chk("reset.wd",        32'(wd),        0);
        chk("reset.pending",   32'(pending),   0);
        chk("reset.alu_ready", 32'(alu_ready), 0);
        chk("reset.fwd_hit1",  32'(fwd_hit1),  0);
        chk("reset.fwd_hit2",  32'(fwd_hit2),  0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < NVEC; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            drive(vecs[v].av, vecs[v].ard, vecs[v].ad, vecs[v].lv, vecs[v].lrd, vecs[v].ldd,
                  vecs[v].a1, vecs[v].a2);
            #1;
            chk({tag, ".alu_ready"}, 32'(alu_ready), 32'(vecs[v].e_rdy));
            chk({tag, ".we"},        32'(we),        32'(vecs[v].e_we));
            chk({tag, ".wa"},        32'(wa),        32'(vecs[v].e_wa));
            chk({tag, ".wd"},        32'(wd),        32'(vecs[v].e_wd));
            chk({tag, ".pending"},   32'(pending),   32'(vecs[v].e_pend));
            chk({tag, ".fwd_hit1"},  32'(fwd_hit1),  32'(vecs[v].e_h1));
            chk({tag, ".fwd_data1"}, 32'(fwd_data1), 32'(vecs[v].e_d1));
            chk({tag, ".fwd_hit2"},  32'(fwd_hit2),  32'(vecs[v].e_h2));
            chk({tag, ".fwd_data2"}, 32'(fwd_data2), 32'(vecs[v].e_d2));
            model_step();
            @(negedge clk);
        end

        // Mid-run asynchronous reset with two queued entries and a live write.
        drive(0, 0, 0, 0, 0, 0, 4, 3);
        #1;
        chk("prereset.pending", 32'(pending), 3);
        rst_n = 1'b0;
        #1;
        chk("midreset.we",        32'(we),        0);
        chk("midreset.pending",   32'(pending),   0);
        chk("midreset.fwd_hit1",  32'(fwd_hit1),  0);
        chk("midreset.fwd_hit2",  32'(fwd_hit2),  0);
        chk("midreset.fwd_data1", 32'(fwd_data1), 0);
        chk("midreset.alu_ready", 32'(alu_ready), 0);
        chk("midreset.wd",        32'(wd),        0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("postreset%0d.we", c),        32'(we),        0);
            chk($sformatf("postreset%0d.pending", c),   32'(pending),   0);
            chk($sformatf("postreset%0d.fwd_hit1", c),  32'(fwd_hit1),  0);
            chk($sformatf("postreset%0d.alu_ready", c), 32'(alu_ready), 1);
            model_step();
            @(negedge clk);
        end

        // Randomized traffic; load density varies so the queue fills and drains.
        for (int c = 0; c < 600; c++) begin
            int lpct;
            lpct = (c / 100) % 2 == 0 ? 30 : 70;
            drive($urandom_range(0, 99) < 60, 3'($urandom), 16'($urandom),
                  $urandom_range(0, 99) < lpct, 3'($urandom), 16'($urandom),
                  3'($urandom), 3'($urandom));
            #1;
            model_compare($sformatf("rand%0d", c));
            model_step();
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
